// File: rtl/dmem_write_buffer.sv
// Posted-store FIFO between the core data port and dmem, with load forwarding.
// Optional store coalescing into the youngest entry when WB_COALESCE_EN is defined.
module dmem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [AW-1:0]            dataadr,
    input  logic [DW-1:0]            writedata,
    output logic                     stall,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_coal;
    logic [DEPTH-1:0] w_coal_we;

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_match;
    logic [AW-1:0]    w_addr [DEPTH];
    logic [DW-1:0]    w_data [DEPTH];

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    assign mem_we    = !w_empty;
    assign mem_addr  = w_addr[r_head];
    assign mem_wdata = w_data[r_head];
    assign count     = r_count;
    assign empty     = w_empty;

    assign w_pop  = mem_we && mem_ready;
    assign stall  = memwrite && w_full && !w_coal;
    assign w_push = memwrite && !stall && !w_coal;

`ifdef WB_COALESCE_EN
    logic [PW-1:0] w_tail_m1;
    assign w_tail_m1 = r_tail - PW'(1);
    // A youngest entry that is leaving this cycle cannot absorb the store.
    assign w_coal = memwrite && !w_empty
                 && (w_addr[w_tail_m1][AW-1:2] == dataadr[AW-1:2])
                 && !(w_pop && (w_tail_m1 == r_head));
    always_comb begin
        w_coal_we = '0;
        if (w_coal) begin
            w_coal_we[w_tail_m1] = 1'b1;
        end
    end
`else
    assign w_coal    = 1'b0;
    assign w_coal_we = '0;
`endif

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic          r_valid;
            logic [AW-1:0] r_addr;
            logic [DW-1:0] r_data;
            logic          w_alloc;
            logic          w_free;

            assign w_alloc = w_push && (r_tail == PW'(gi));
            assign w_free  = w_pop  && (r_head == PW'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid <= 1'b0;
                end else if (w_alloc) begin
                    r_valid <= 1'b1;
                end else if (w_free) begin
                    r_valid <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (w_alloc) begin
                    r_addr <= dataadr;
                    r_data <= writedata;
                end else if (w_coal_we[gi]) begin
                    r_data <= writedata;
                end
            end

            assign w_valid[gi] = r_valid;
            assign w_addr[gi]  = r_addr;
            assign w_data[gi]  = r_data;
            assign w_match[gi] = r_valid && (r_addr[AW-1:2] == dataadr[AW-1:2]);
        end
    endgenerate

    // Walk oldest to youngest so the entry nearest the tail wins.
    always_comb begin
        logic [PW-1:0] w_fwd_idx;
        w_fwd_idx = '0;
        fwd_hit   = 1'b0;
        fwd_data  = '0;
        if (!memwrite) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_fwd_idx = r_head + PW'(i);
                if (w_match[w_fwd_idx]) begin
                    fwd_hit  = 1'b1;
                    fwd_data = w_data[w_fwd_idx];
                end
            end
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= w_count_next;
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed testbench for dmem_write_buffer: reset, drain order, stall, forwarding,
// simultaneous push/pop, reset mid-drain and (optionally) coalescing.
module tb_dmem_write_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        stall;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [2:0]  count;
    logic        empty;

    int n_cmp = 0;
    int n_err = 0;

    dmem_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .stall     (stall),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .count     (count),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        memwrite  = 1'b0;
        mem_ready = 1'b0;
        dataadr   = '0;
        writedata = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        #1;
        $display("store addr=%0d data=%0d stall=%b count=%0d", a, d, stall, count);
        step();
        memwrite = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", stall); end
        n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL rst_fwd_hit got %b want 0", fwd_hit); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", empty); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
        mem_ready = 1'b1;
        store(32'd84, 32'd7);
        #1;
        n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL t1_mem_we got %b want 1", mem_we); end
        n_cmp++; if (mem_addr !== 32'd84) begin n_err++; $display("FAIL t1_addr got %0d want 84", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'd7) begin n_err++; $display("FAIL t1_data got %0d want 7", mem_wdata); end
        step();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL t1_empty got %b want 1", empty); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL t1_count got %0d want 0", count); end
    endtask

    task automatic test_fill_stall();
        logic [31:0] exp_a [5];
        exp_a = '{32'd80, 32'd84, 32'd88, 32'd92, 32'd96};
        do_reset();
        for (int k = 0; k < 4; k++) store(exp_a[k], exp_a[k] + 32'd1);
        #1;
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL t2_count_full got %0d want 4", count); end
        memwrite  = 1'b1;
        dataadr   = 32'd96;
        writedata = 32'd97;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL t2_stall_full got %b want 1", stall); end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL t2_stall_on_pop got %b want 1", stall); end
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k == 1) begin
                n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL t2_stall_release got %b want 0", stall); end
            end
            $display("drain addr=%0d data=%0d", mem_addr, mem_wdata);
            n_cmp++; if (mem_addr !== exp_a[k]) begin n_err++; $display("FAIL t2_order[%0d] got %0d want %0d", k, mem_addr, exp_a[k]); end
            n_cmp++; if (mem_wdata !== exp_a[k] + 32'd1) begin n_err++; $display("FAIL t2_data[%0d] got %0d want %0d", k, mem_wdata, exp_a[k] + 32'd1); end
            step();
            if (k == 1) memwrite = 1'b0;
        end
        #1;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL t2_empty got %b want 1", empty); end
    endtask

    task automatic test_forward();
        do_reset();
        store(32'd80, 32'd1);
        store(32'd84, 32'd3);
        store(32'd80, 32'd2);
        dataadr = 32'd80;
        #1;
        n_cmp++; if (fwd_hit !== 1'b1) begin n_err++; $display("FAIL t3_hit80 got %b want 1", fwd_hit); end
        n_cmp++; if (fwd_data !== 32'd2) begin n_err++; $display("FAIL t3_data80 got %0d want 2", fwd_data); end
        dataadr = 32'd82;
        #1;
        n_cmp++; if (fwd_data !== 32'd2) begin n_err++; $display("FAIL t3_word82 got %0d want 2", fwd_data); end
        dataadr = 32'd88;
        #1;
        n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL t3_hit88 got %b want 0", fwd_hit); end
        n_cmp++; if (fwd_data !== 32'd0) begin n_err++; $display("FAIL t3_data88 got %0d want 0", fwd_data); end
        dataadr = 32'd84;
        memwrite = 1'b1;
        #1;
        n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL t3_hit_on_store got %b want 0", fwd_hit); end
        memwrite = 1'b0;
        mem_ready = 1'b1;
        step();
        // Head is now 84 and is popped this cycle; it must still forward.
        n_cmp++; if (fwd_data !== 32'd3 || fwd_hit !== 1'b1) begin n_err++; $display("FAIL t3_fwd_popping got %b/%0d want 1/3", fwd_hit, fwd_data); end
        step();
        #1;
        n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL t3_after_pop got %b want 0", fwd_hit); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        store(32'd80, 32'd10);
        store(32'd84, 32'd11);
        mem_ready = 1'b1;
        memwrite  = 1'b1;
        dataadr   = 32'd88;
        writedata = 32'd12;
        #1;
        n_cmp++; if (mem_addr !== 32'd80) begin n_err++; $display("FAIL t4_head got %0d want 80", mem_addr); end
        step();
        memwrite = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL t4_count got %0d want 2", count); end
        n_cmp++; if (mem_wdata !== 32'd11) begin n_err++; $display("FAIL t4_second got %0d want 11", mem_wdata); end
        step();
        n_cmp++; if (mem_addr !== 32'd88 || mem_wdata !== 32'd12) begin n_err++; $display("FAIL t4_third got %0d/%0d want 88/12", mem_addr, mem_wdata); end
        step();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL t4_empty got %b want 1", empty); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        store(32'd80, 32'd1);
        store(32'd84, 32'd2);
        store(32'd88, 32'd3);
        mem_ready = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL t5_mem_we got %b want 0", mem_we); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL t5_count got %0d want 0", count); end
        dataadr = 32'd84;
        step();
        n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL t5_fwd got %b want 0", fwd_hit); end
    endtask

    task automatic test_coalesce();
        do_reset();
        store(32'd80, 32'd1);
        store(32'd80, 32'd5);
        #1;
`ifdef WB_COALESCE_EN
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL t6_count got %0d want 1", count); end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (mem_wdata !== 32'd5) begin n_err++; $display("FAIL t6_data got %0d want 5", mem_wdata); end
        step();
`else
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL t6_count got %0d want 2", count); end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (mem_wdata !== 32'd1) begin n_err++; $display("FAIL t6_first got %0d want 1", mem_wdata); end
        step();
        n_cmp++; if (mem_addr !== 32'd80 || mem_wdata !== 32'd5) begin n_err++; $display("FAIL t6_second got %0d/%0d want 80/5", mem_addr, mem_wdata); end
        step();
`endif
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL t6_empty got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_forward();
        test_back_to_back();
        test_reset_mid_drain();
        test_coalesce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
